// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and configuration sanity check for the handshake FIFO.
package sync_fifo_pkg;

  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two and the flag thresholds must be ordered and in range.
  function automatic bit fifo_cfg_ok(input int depth, input int ae, input int af);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_hs.sv
// Single-clock valid/ready FIFO with fall-through or registered head, level and
// almost-full/almost-empty flags, synchronous flush.
module sync_fifo_hs import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter bit FALL_THROUGH = 1'b1,
  parameter int AF_THRESH    = DEPTH - 2,
  parameter int AE_THRESH    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [fifo_lvl_w(DEPTH)-1:0]  level,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int LW = fifo_lvl_w(DEPTH);

  if (!fifo_cfg_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_cfg_err
    $error("sync_fifo_hs: DEPTH must be a power of 2 >= 2 and AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  in_ready_q, af_q, ae_q;
  logic                  wr_en, rd_en, mem_pop, mem_empty;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign wr_en     = in_valid && in_ready_q;
  assign rd_en     = out_valid && out_ready;
  assign mem_empty = (wr_ptr_q == rd_ptr_q);

  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en && !flush),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (mem_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Flags are registered from the next level so they never lag the level output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= (level_d < LW'(DEPTH));
      af_q       <= (level_d >= LW'(AF_THRESH));
      ae_q       <= (level_d <= LW'(AE_THRESH));
    end
  end

  if (FALL_THROUGH) begin : g_ft
    assign mem_pop   = rd_en;
    assign out_valid = !mem_empty;
    // Gate storage so an empty FIFO shows zero rather than stale contents.
    assign out_data  = out_valid ? mem_rdata : '0;
  end else begin : g_reg
    logic                  ovalid_q;
    logic [DATA_WIDTH-1:0] odata_q;

    assign mem_pop = !mem_empty && (!ovalid_q || rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovalid_q <= 1'b0;
        odata_q  <= '0;
      end else if (flush) begin
        ovalid_q <= 1'b0;
        odata_q  <= '0;
      end else if (mem_pop) begin
        ovalid_q <= 1'b1;
        odata_q  <= mem_rdata;
      end else if (rd_en) begin
        ovalid_q <= 1'b0;
      end
    end

    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
  end

  assign in_ready     = in_ready_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Directed self-checking bench; runs the same suite on a fall-through and a registered-output instance.
module tb_sync_fifo_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       mode = 1'b1;

  logic       ir1, ov1, af1, ae1, ir0, ov0, af0, ae0;
  logic [7:0] od1, od0;
  logic [4:0] lv1, lv0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_hs #(.DATA_WIDTH(8), .DEPTH(16), .FALL_THROUGH(1'b1)) u_ft1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid & mode), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready & mode), .out_data(od1),
    .level(lv1), .almost_full(af1), .almost_empty(ae1)
  );

  sync_fifo_hs #(.DATA_WIDTH(8), .DEPTH(16), .FALL_THROUGH(1'b0)) u_ft0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid & ~mode), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready & ~mode), .out_data(od0),
    .level(lv0), .almost_full(af0), .almost_empty(ae0)
  );

  logic       s_ir, s_ov, s_af, s_ae;
  logic [7:0] s_od;
  logic [4:0] s_lv;
  assign s_ir = mode ? ir1 : ir0;
  assign s_ov = mode ? ov1 : ov0;
  assign s_af = mode ? af1 : af0;
  assign s_ae = mode ? ae1 : ae0;
  assign s_od = mode ? od1 : od0;
  assign s_lv = mode ? lv1 : lv0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s mode=%0d got=%0h exp=%0h", tag, mode, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_suite();
    // reset
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", s_ir, 1);
    chk("rst_out_valid", s_ov, 0);
    chk("rst_out_data", s_od, 0);
    chk("rst_level", s_lv, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    rst_n = 1'b1;
    step();

    // single word
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_level", s_lv, 1);
    if (!mode) begin
      chk("single_ov_early", s_ov, 0);
      step();
    end
    chk("single_ov", s_ov, 1);
    chk("single_data", s_od, 8'hA5);
    step();
    chk("single_level_end", s_lv, 0);
    chk("single_ov_end", s_ov, 0);

    // fill to full
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      chk("fill_in_ready", s_ir, 1);
      step();
      chk("fill_level", s_lv, i + 1);
      chk("fill_af", s_af, (i + 1 >= 14) ? 1 : 0);
    end
    chk("full_in_ready", s_ir, 0);
    in_data = 8'hEE;
    step();
    chk("full_reject_level", s_lv, 16);
    // full with simultaneous read: read happens, write rejected
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fullrd_level", s_lv, 15);
    chk("fullrd_in_ready", s_ir, 1);
    for (int i = 1; i < 16; i++) begin
      chk("drain_ov", s_ov, 1);
      chk("drain_data", s_od, i);
      chk("drain_level", s_lv, 16 - i);
      chk("drain_ae", s_ae, (16 - i <= 1) ? 1 : 0);
      step();
    end
    chk("drain_end_level", s_lv, 0);
    chk("drain_end_ov", s_ov, 0);
    chk("drain_end_ae", s_ae, 1);

    // streaming through wrap
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    chk("prefill_level", s_lv, 3);
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_valid = (k + 3 < 100);
      in_data = 8'(k + 3);
      chk("stream_ov", s_ov, 1);
      chk("stream_data", s_od, k);
      if (k < 97) chk("stream_level", s_lv, 3);
      step();
    end
    in_valid = 1'b0;
    chk("stream_end_level", s_lv, 0);

    // flush mid-op
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      step();
    end
    chk("preflush_level", s_lv, 7);
    flush = 1'b1; in_data = 8'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", s_lv, 0);
    chk("flush_ov", s_ov, 0);
    chk("flush_in_ready", s_ir, 1);
    chk("flush_ae", s_ae, 1);
    step();
    chk("flush_ov_after", s_ov, 0);

    // async reset mid-op
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    chk("prerst_level", s_lv, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", s_lv, 0);
    chk("arst_ov", s_ov, 0);
    chk("arst_od", s_od, 0);
    chk("arst_in_ready", s_ir, 1);
    chk("arst_ae", s_ae, 1);
    chk("arst_af", s_af, 0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("post_rst_accept", s_lv, 1);
    step();
    if (!mode) step();
    chk("post_rst_data", s_od, 8'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    mode = 1'b1;
    run_suite();
    mode = 1'b0;
    run_suite();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
